// File: rtl/nearest_centroid_if.sv
// nearest_centroid_if: point intake, result output and distance-unit link of the
// nearest-centroid block; slave is the block side, master is the surrounding datapath.
interface nearest_centroid_if #(
    parameter int IDX_W = 2
);
    logic             pt_valid;
    logic             pt_ready;
    logic [7:0]       pt_x;
    logic [7:0]       pt_y;
    logic [7:0]       d_x0;
    logic [7:0]       d_x1;
    logic [7:0]       d_y0;
    logic [7:0]       d_y1;
    logic [15:0]      d_sq;
    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_idx;
    logic [15:0]      res_dist;
    modport master (
        output pt_valid, pt_x, pt_y, res_ready, d_sq,
        input  pt_ready, d_x0, d_x1, d_y0, d_y1, res_valid, res_idx, res_dist
    );
    modport slave (
        input  pt_valid, pt_x, pt_y, res_ready, d_sq,
        output pt_ready, d_x0, d_x1, d_y0, d_y1, res_valid, res_idx, res_dist
    );
endinterface

// File: rtl/nearest_centroid.sv
// nearest_centroid: streams one point against every active centroid through an external
// pipelined distance unit and reports the index and distance of the closest one.
module nearest_centroid #(
    parameter int K     = 4,
    parameter int IDX_W = 2,
    parameter int LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cent_we,
    input  logic [IDX_W-1:0]  i_cent_addr,
    input  logic [7:0]        i_cent_x,
    input  logic [7:0]        i_cent_y,
    input  logic [IDX_W:0]    i_num_cent,
    nearest_centroid_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
    localparam logic [IDX_W:0]   ONE   = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   KN    = (IDX_W+1)'(K);
    localparam logic [IDX_W-1:0] ONE_I = IDX_W'(1);
    state_t           r_state;
    logic [7:0]       r_cx [K];
    logic [7:0]       r_cy [K];
    logic [7:0]       r_px, r_py;
    logic [IDX_W:0]   r_n;
    logic [IDX_W-1:0] r_i;
    logic [LAT-1:0]   r_tag_v;
    logic [IDX_W-1:0] r_tag_idx [LAT];
    logic             r_first;
    logic [15:0]      r_min_dist;
    logic [IDX_W-1:0] r_min_idx;
    logic             r_res_valid;
    logic [IDX_W-1:0] r_res_idx;
    logic [15:0]      r_res_dist;
    logic             w_issue, w_last_issue, w_ret, w_ret_last, w_better;
    logic [IDX_W-1:0] w_ret_idx, w_min_idx;
    logic [15:0]      w_min_dist;
    logic [IDX_W:0]   w_n;
    always_comb begin
        w_n          = (i_num_cent == '0) ? ONE : (i_num_cent > KN) ? KN : i_num_cent;
        w_issue      = r_state == ISSUE;
        w_last_issue = w_issue && ({1'b0, r_i} == r_n - ONE);
        w_ret        = r_tag_v[LAT-1];
        w_ret_idx    = r_tag_idx[LAT-1];
        w_ret_last   = w_ret && ({1'b0, w_ret_idx} == r_n - ONE);
        // strict compare keeps the lower index on ties
        w_better     = r_first || (bus.d_sq < r_min_dist);
        w_min_dist   = w_better ? bus.d_sq : r_min_dist;
        w_min_idx    = w_better ? w_ret_idx : r_min_idx;
    end
    assign bus.pt_ready  = r_state == IDLE;
    assign bus.d_x0      = r_px;
    assign bus.d_y0      = r_py;
    assign bus.d_x1      = w_issue ? r_cx[r_i] : 8'd0;
    assign bus.d_y1      = w_issue ? r_cy[r_i] : 8'd0;
    assign bus.res_valid = r_res_valid;
    assign bus.res_idx   = r_res_idx;
    assign bus.res_dist  = r_res_dist;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cx        <= '{default: '0};
            r_cy        <= '{default: '0};
            r_px        <= '0;
            r_py        <= '0;
            r_n         <= ONE;
            r_i         <= '0;
            r_tag_v     <= '0;
            r_tag_idx   <= '{default: '0};
            r_first     <= 1'b0;
            r_min_dist  <= '0;
            r_min_idx   <= '0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_dist  <= '0;
        end else begin
            r_tag_v      <= {r_tag_v[LAT-2:0], w_issue};
            r_tag_idx[0] <= r_i;
            for (int j = 1; j < LAT; j++) r_tag_idx[j] <= r_tag_idx[j-1];
            if (w_ret) begin
                r_first    <= 1'b0;
                r_min_dist <= w_min_dist;
                r_min_idx  <= w_min_idx;
            end
            case (r_state)
                IDLE: begin
                    if (i_cent_we) begin
                        r_cx[i_cent_addr] <= i_cent_x;
                        r_cy[i_cent_addr] <= i_cent_y;
                    end
                    if (bus.pt_valid) begin
                        r_px    <= bus.pt_x;
                        r_py    <= bus.pt_y;
                        r_n     <= w_n;
                        r_i     <= '0;
                        r_first <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_i <= r_i + ONE_I;
                    if (w_last_issue) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_ret_last) begin
                        r_res_valid <= 1'b1;
                        r_res_idx   <= w_min_idx;
                        r_res_dist  <= w_min_dist;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nearest_centroid.sv
// tb_nearest_centroid: directed and random points against a reference nearest-centroid
// model, with a behavioural 3-cycle distance unit closing the loop.
module tb_nearest_centroid;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cent_we = 1'b0;
    logic [1:0] i_cent_addr = '0;
    logic [7:0] i_cent_x = '0, i_cent_y = '0;
    logic [2:0] i_num_cent = '0;
    int         total = 0, bad = 0, hs = 0;
    int         m_cx [4], m_cy [4];
    logic [15:0] du [3];

    nearest_centroid_if #(.IDX_W(2)) bus ();

    nearest_centroid #(.K(4), .IDX_W(2), .LAT(3)) dut (
        .clk(clk), .rst(rst), .i_cent_we(i_cent_we), .i_cent_addr(i_cent_addr),
        .i_cent_x(i_cent_x), .i_cent_y(i_cent_y), .i_num_cent(i_num_cent), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int ddist(int px, int py, int cx, int cy);
        return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) >> 1;
    endfunction

    function automatic int clampn(int n);
        return (n == 0) ? 1 : (n > 4) ? 4 : n;
    endfunction

    always @(posedge clk) begin
        if (rst) du <= '{default: '0};
        else begin
            du[0] <= 16'(ddist(bus.d_x0, bus.d_y0, bus.d_x1, bus.d_y1));
            du[1] <= du[0];
            du[2] <= du[1];
        end
    end
    assign bus.d_sq = du[2];

    always @(posedge clk) if (bus.res_valid && bus.res_ready) hs <= hs + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_best(input int px, input int py, input int n, output int bi, output int bd);
        bi = 0;
        bd = ddist(px, py, m_cx[0], m_cy[0]);
        for (int j = 1; j < n; j++)
            if (ddist(px, py, m_cx[j], m_cy[j]) < bd) begin
                bi = j;
                bd = ddist(px, py, m_cx[j], m_cy[j]);
            end
    endtask

    task automatic write_cent(input int a, input int x, input int y);
        i_cent_we = 1'b1; i_cent_addr = 2'(a); i_cent_x = 8'(x); i_cent_y = 8'(y);
        @(negedge clk);
        i_cent_we = 1'b0;
        m_cx[a] = x; m_cy[a] = y;
    endtask

    task automatic run_point(input string tag, input int px, input int py, input int nc, input int hold);
        int n, ei, ed, c, ridx, rdist;
        n = clampn(nc);
        model_best(px, py, n, ei, ed);
        i_num_cent = 3'(nc); bus.pt_x = 8'(px); bus.pt_y = 8'(py); bus.pt_valid = 1'b1;
        check({tag, ".ready"}, bus.pt_ready, 1);
        @(posedge clk);
        #1 bus.pt_valid = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (c <= n) begin
                check({tag, ".dx1"}, bus.d_x1, m_cx[c-1]);
                check({tag, ".dy1"}, bus.d_y1, m_cy[c-1]);
                check({tag, ".dx0"}, bus.d_x0, px);
            end
        end while (!bus.res_valid && c < 40);
        check({tag, ".lat"}, c, n + 4);
        check({tag, ".idx"}, bus.res_idx, ei);
        check({tag, ".dist"}, bus.res_dist, ed);
        ridx = bus.res_idx; rdist = bus.res_dist;
        repeat (hold) begin
            i_cent_we = 1'b1; i_cent_addr = 2'd1; i_cent_x = 8'd200; i_cent_y = 8'd200;
            @(negedge clk);
            check({tag, ".hold_v"}, bus.res_valid, 1);
            check({tag, ".hold_i"}, bus.res_idx, ridx);
            check({tag, ".hold_d"}, bus.res_dist, rdist);
            check({tag, ".hold_r"}, bus.pt_ready, 0);
        end
        i_cent_we = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check({tag, ".drop"}, bus.res_valid, 0);
        check({tag, ".idle"}, bus.pt_ready, 1);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int bx [3], by [3];
        int ei, ed, c, hs0, nc;
        bx = '{7, 200, 50};
        by = '{9, 180, 60};
        bus.pt_valid = 1'b0; bus.pt_x = '0; bus.pt_y = '0; bus.res_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin m_cx[j] = 0; m_cy[j] = 0; end
        repeat (3) @(negedge clk);
        check("rst.ready", bus.pt_ready, 1);
        check("rst.valid", bus.res_valid, 0);
        check("rst.idx", bus.res_idx, 0);
        check("rst.dist", bus.res_dist, 0);
        check("rst.d", {bus.d_x0, bus.d_x1, bus.d_y0, bus.d_y1}, 0);
        rst = 1'b0;
        @(negedge clk);

        write_cent(0, 0, 0); write_cent(1, 12, 18); write_cent(2, 100, 100);
        run_point("basic", 10, 20, 3, 0);
        check("basic.ref_idx", bus.res_idx, 1);
        check("basic.ref_dist", bus.res_dist, 4);

        write_cent(0, 5, 5); write_cent(1, 15, 15);
        run_point("tie", 10, 10, 2, 0);
        check("tie.ref", {bus.res_idx, bus.res_dist}, {2'd0, 16'd25});

        write_cent(0, 30, 30); write_cent(1, 40, 40); write_cent(2, 90, 90); write_cent(3, 10, 10);
        run_point("bp", 38, 41, 4, 10);
        run_point("lock", 190, 195, 4, 0);

        run_point("n0", 80, 80, 0, 0);
        run_point("n7", 12, 12, 7, 0);
        write_cent(0, 0, 0);
        run_point("max", 255, 255, 1, 0);
        check("max.ref", bus.res_dist, 65025);

        write_cent(0, 20, 20); write_cent(1, 60, 60); write_cent(2, 7, 3);
        i_num_cent = 3'd3; bus.pt_x = 8'd9; bus.pt_y = 8'd9; bus.pt_valid = 1'b1;
        @(posedge clk);
        #1 bus.pt_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.valid", bus.res_valid, 0);
        check("rstmid.ready", bus.pt_ready, 1);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin m_cx[j] = 0; m_cy[j] = 0; end
        @(negedge clk);
        run_point("rstpt", 3, 4, 1, 0);
        check("rstpt.ref", {bus.res_idx, bus.res_dist}, {2'd0, 16'd12});

        write_cent(0, 10, 10); write_cent(1, 190, 190); write_cent(2, 60, 55);
        hs0 = hs;
        bus.res_ready = 1'b1; i_num_cent = 3'd3; bus.pt_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.pt_x = 8'(bx[k]); bus.pt_y = 8'(by[k]);
            model_best(bx[k], by[k], 3, ei, ed);
            c = 0;
            do begin @(negedge clk); c++; end while (!bus.res_valid && c < 40);
            check("b2b.lat", c, (k == 0) ? 7 : 8);
            check("b2b.idx", bus.res_idx, ei);
            check("b2b.dist", bus.res_dist, ed);
        end
        bus.pt_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b.count", hs - hs0, 3);
        check("b2b.quiet", bus.res_valid, 0);
        bus.res_ready = 1'b0;

        for (int r = 0; r < 12; r++) begin
            int lim;
            lim = (r % 2 == 0) ? 15 : 255;
            for (int j = 0; j < 4; j++) write_cent(j, $urandom_range(0, lim), $urandom_range(0, lim));
            nc = $urandom_range(0, 7);
            run_point("rand", $urandom_range(0, lim), $urandom_range(0, lim), nc, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nearest_centroid.md
Name: nearest_centroid

Overview:
- Assigns one point to its nearest cluster centroid.
- Holds a small centroid table and accepts points over a valid/ready handshake.
- Streams one (point, centroid) pair per cycle into the team's pipelined distance unit. That unit's contract: 3-cycle latency, output = (dx² + dy²) >> 1, 16-bit.
- Collects the returned squared distances, tracks the minimum, and emits the winning index and distance.
- Acts as the initiator/consumer at the other end of the distance-unit interface in the clustering datapath.

Parameters:
- K, 4: centroid table depth (max centroids).
- IDX_W, 2: index width, clog2(K).
- LAT, 3: distance-unit latency in clock edges.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. The distance unit shares this reset.
- cent_we  in  1  centroid table write strobe.
- cent_addr  in  IDX_W  table write address.
- cent_x  in  8  centroid x, unsigned.
- cent_y  in  8  centroid y, unsigned.
- num_cent  in  IDX_W+1  number of active centroids.
- pt_valid  in  1  point available.
- pt_ready  out  1  block can accept a point.
- pt_x  in  8  point x.
- pt_y  in  8  point y.
- d_x0  out  8  to distance unit: point x.
- d_x1  out  8  to distance unit: centroid x.
- d_y0  out  8  to distance unit: point y.
- d_y1  out  8  to distance unit: centroid y.
- d_sq  in  16  from distance unit: halved squared distance.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_idx  out  IDX_W  index of nearest centroid.
- res_dist  out  16  its d_sq value.

Behaviour:
- Reset:
  - FSM goes to IDLE; issue counter, tag pipeline, min registers and centroid table are cleared to 0.
  - Outputs: pt_ready=1 (IDLE), res_valid=0, res_idx=0, res_dist=0, d_*=0.
  - Reset mid-operation abandons the point; in-flight tags are discarded.
- Centroid table:
  - A write happens at the clk edge when cent_we=1 and the FSM is in IDLE.
  - cent_we is ignored in every other state, so the table is stable for the duration of a point.
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - pt_ready=1.
  - On pt_valid: latch pt_x/pt_y and N = clamp(num_cent, 1, K) (0 → 1, >K → K); clear issue counter i; go to ISSUE.
- ISSUE:
  - Each cycle drives d_x0=pt_x, d_y0=pt_y (latched) and d_x1/d_y1 = table[i].
  - Pushes tag {valid=1, idx=i} into a LAT-stage shift register, then i++.
  - After the cycle with i=N-1, go to DRAIN.
  - Outside ISSUE, d_x1/d_y1=0, d_x0/d_y0 hold the latched point, and pushed tags are invalid.
- Tag return:
  - Pairs driven in cycle t produce d_sq valid in cycle t+LAT, aligned with the tag exiting the shift register.
  - On the first returned tag: min_dist=d_sq, min_idx=tag.idx.
  - On later tags: update only if d_sq < min_dist (strict), so ties keep the lower index.
- DRAIN:
  - When the tag for index N-1 is consumed, go to HOLD.
  - res_idx/res_dist are loaded from the final min values, including that last comparison.
- HOLD:
  - res_valid=1; res_idx/res_dist stay stable while res_valid=1 and res_ready=0.
  - On res_ready=1: res_valid drops next cycle; go to IDLE.
- Latency:
  - Point accepted at edge E0 → ISSUE occupies cycles 1..N → last d_sq in cycle N+LAT → res_valid=1 in cycle N+LAT+1.
  - Example: N=3, LAT=3 gives res_valid 7 cycles after acceptance.
- Throughput: one point per N+LAT+2 cycles minimum; no overlap between points.
- Arithmetic: comparison is unsigned 16-bit; max d_sq is 65025, no overflow.
- pt_valid in a non-IDLE state is not accepted (pt_ready=0) and must be held by the source.

Test Plan:
- Basic assignment:
  - Table (0,0),(12,18),(100,100); N=3; point (10,20).
  - Expected d_sq sequence 250, 4, 7250 → res_idx=1, res_dist=4.
  - res_valid high exactly 7 cycles after acceptance.
- Tie:
  - Table (5,5),(15,15); N=2; point (10,10).
  - Both d_sq=25 → res_idx=0, res_dist=25.
- Backpressure and table lock:
  - res_ready=0 for 10 cycles → res_valid held, outputs stable, pt_ready=0.
  - cent_we pulses during HOLD do not change the table; the next point uses the old table.
- Boundary:
  - num_cent=0 → one centroid evaluated, res_idx=0.
  - num_cent=7 (K=4) → four evaluated.
  - Point (255,255), centroid (0,0) → res_dist=65025.
- Reset mid-operation:
  - Assert rst during DRAIN → next cycle res_valid=0, pt_ready=1, table zeroed.
  - Next point (3,4) with N=1 → res_idx=0, res_dist=12.
- Back-to-back points:
  - Assert pt_valid continuously with three points → exactly three results in order.
  - No tag from one point contaminates the next point's minimum.
